// File: rtl/multi_cycle_core.sv
// multi_cycle_core: five-state multi-cycle MIPS subset core sharing one memory port for fetch and data.
// Define MULTI_CYCLE_CORE_JAL_EN to make opcode 03h (jal) legal; otherwise it decodes as illegal.
module multi_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       PC_out,
  output logic [31:0]       ALU_out,
  output logic [31:0]       MEM_out,
  output logic              retire,
  output logic              illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_SLT    = 6'h2A;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_alu;
  logic [31:0] r_mem;
  logic        r_rst_q;
  logic [31:0] r_rf [32];

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [31:0] w_simm;
  logic [31:0] w_rd_a;
  logic [31:0] w_rd_b;
  logic [31:0] w_alu;

  logic w_is_r;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_beq;
  logic w_is_addi;
  logic w_is_j;
  logic w_is_jal;
  logic w_legal;

  logic w_mem_phase;
  logic w_mem_go;
  logic w_retire;
  logic w_illegal;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;

  // Instruction fields
  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_shamt = r_ir[10:6];
  assign w_funct = r_ir[5:0];
  assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};

  always_comb begin
    w_is_r = 1'b0;
    if (w_op == OP_RTYPE && w_shamt == 5'd0) begin
      case (w_funct)
        F_ADD, F_SUB, F_AND, F_OR, F_SLT: w_is_r = 1'b1;
        default:                          w_is_r = 1'b0;
      endcase
    end
  end

  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_sw   = (w_op == OP_SW);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_addi = (w_op == OP_ADDI);
  assign w_is_j    = (w_op == OP_J);

`ifdef MULTI_CYCLE_CORE_JAL_EN
  localparam logic [5:0] OP_JAL = 6'h03;
  assign w_is_jal = (w_op == OP_JAL);
`else
  assign w_is_jal = 1'b0;
`endif

  assign w_legal = w_is_r | w_is_lw | w_is_sw | w_is_beq | w_is_addi | w_is_j | w_is_jal;

  // r0 is held at zero by reset and never written, so no read-side mux is needed
  assign w_rd_a = r_rf[w_rs];
  assign w_rd_b = r_rf[w_rt];

  always_comb begin
    w_alu = r_a + w_simm;
    if (w_is_r) begin
      case (w_funct)
        F_ADD:   w_alu = r_a + r_b;
        F_SUB:   w_alu = r_a - r_b;
        F_AND:   w_alu = r_a & r_b;
        F_OR:    w_alu = r_a | r_b;
        F_SLT:   w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
        default: w_alu = r_a + r_b;
      endcase
    end
  end

  // r_rst_q keeps the port idle for the cycle following a sampled reset
  assign w_mem_phase = ((r_state == FETCH) || (r_state == MEM)) && !r_rst_q;
  assign w_mem_go    = w_mem_phase & mem_ready;

  assign mem_req   = w_mem_phase;
  assign mem_we    = (r_state == MEM) && w_is_sw;
  assign mem_addr  = (r_state == MEM) ? r_alu[ADDR_W-1:0] : r_pc[ADDR_W-1:0];
  assign mem_wdata = r_b;

  assign PC_out  = r_pc;
  assign ALU_out = r_alu;
  assign MEM_out = r_mem;
  assign retire  = w_retire & ~Reset;
  assign illegal = w_illegal & ~Reset;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_illegal  = 1'b0;
    w_rf_we    = 1'b0;
    w_rf_waddr = 5'd0;
    w_rf_wdata = '0;
    case (r_state)
      FETCH: begin
        if (w_mem_go) w_next = DECODE;
      end
      DECODE: begin
        if (w_legal) begin
          w_next = EXEC;
        end else begin
          w_illegal = 1'b1;
          w_retire  = 1'b1;
          w_next    = FETCH;
        end
      end
      EXEC: begin
        if (w_is_r || w_is_addi) begin
          w_next = WB;
        end else if (w_is_lw || w_is_sw) begin
          w_next = MEM;
        end else begin
          w_retire = 1'b1;
          w_next   = FETCH;
        end
        if (w_is_jal) begin
          w_rf_we    = 1'b1;
          w_rf_waddr = 5'd31;
          w_rf_wdata = r_pc;
        end
      end
      MEM: begin
        if (w_mem_go) begin
          if (w_is_sw) begin
            w_retire = 1'b1;
            w_next   = FETCH;
          end else begin
            w_next = WB;
          end
        end
      end
      WB: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = w_is_r ? w_rd : w_rt;
        w_rf_wdata = w_is_lw ? r_mem : r_alu;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_alu   <= '0;
      r_mem   <= '0;
      r_rst_q <= 1'b1;
    end else begin
      r_rst_q <= 1'b0;
      case (r_state)
        FETCH: begin
          if (w_mem_go) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + 32'd4;
          end
        end
        DECODE: begin
          r_a <= w_rd_a;
          r_b <= w_rd_b;
        end
        EXEC: begin
          if (w_is_r || w_is_addi || w_is_lw || w_is_sw) r_alu <= w_alu;
          if (w_is_beq && (r_a == r_b)) r_pc <= r_pc + {w_simm[29:0], 2'b00};
          if (w_is_j || w_is_jal) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
        end
        MEM: begin
          if (w_mem_go && w_is_lw) r_mem <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rf <= '{default: '0};
    end else if (w_rf_we && (w_rf_waddr != 5'd0)) begin
      r_rf[w_rf_waddr] <= w_rf_wdata;
    end
  end

endmodule

// File: tb/tb_multi_cycle_core.sv
// Directed bench for multi_cycle_core: small programs in a behavioural memory with programmable wait states.
module tb_multi_cycle_core;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] PC_out;
  logic [31:0] ALU_out;
  logic [31:0] MEM_out;
  logic        retire;
  logic        illegal;

  multi_cycle_core #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .Clock(Clock), .Reset(Reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .PC_out(PC_out), .ALU_out(ALU_out), .MEM_out(MEM_out),
    .retire(retire), .illegal(illegal)
  );

  always #5 Clock = ~Clock;

  logic [31:0] mem [64];
  int   delay = 0;
  logic spur  = 1'b0;
  int   wcnt  = 0;
  int   cyc   = 0;

  // spur forces ready high even when no request is outstanding
  assign mem_ready = (mem_req && (wcnt == delay)) || spur;
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge Clock) begin
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_req && mem_we && mem_ready) mem[mem_addr[7:2]] <= mem_wdata;
    cyc <= Reset ? 0 : cyc + 1;
  end

  int          rt_n, ill_n, ill_alone, f_n, wr_n, stab_viol;
  int          rt_cyc [64];
  logic [31:0] f_addr [64];
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic        pend;
  logic [31:0] p_addr, p_wd;
  logic        p_we;

  always @(negedge Clock) begin
    if (Reset) begin
      rt_n = 0; ill_n = 0; ill_alone = 0; f_n = 0; wr_n = 0; stab_viol = 0; pend = 1'b0;
    end else begin
      if (retire) begin
        if (rt_n < 64) rt_cyc[rt_n] = cyc;
        rt_n++;
      end
      if (illegal) begin
        ill_n++;
        if (!retire) ill_alone++;
      end
      if (mem_req && !mem_we && mem_ready && f_n < 64) begin
        f_addr[f_n] = mem_addr;
        f_n++;
      end
      if (mem_req && mem_we && mem_ready && wr_n < 16) begin
        wr_addr[wr_n] = mem_addr;
        wr_data[wr_n] = mem_wdata;
        wr_n++;
      end
      if (pend && (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wd))
        stab_viol++;
      pend   = mem_req && !mem_ready;
      p_addr = mem_addr;
      p_we   = mem_we;
      p_wd   = mem_wdata;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge Clock);
    #3;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    mem[a[7:2]] = d;
  endtask

  task automatic hold_reset(input int dly, input logic spr);
    Reset = 1'b1;
    delay = dly;
    spur  = spr;
    run(1);
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic release_reset();
    run(1);
    Reset = 1'b0;
  endtask

  task automatic reset_state_checks(input string t);
    chk({t, "_rst_pc"}, PC_out, 32'h0);
    chk({t, "_rst_alu"}, ALU_out, 32'h0);
    chk({t, "_rst_mem"}, MEM_out, 32'h0);
    chk({t, "_rst_req"}, 32'(mem_req), 32'h0);
    chk({t, "_rst_retire"}, 32'(retire), 32'h0);
    chk({t, "_rst_illegal"}, 32'(illegal), 32'h0);
  endtask

  task automatic load_prog_a();
    put(32'h00, 32'h20010005);  // addi r1,r0,5
    put(32'h04, 32'h20020007);  // addi r2,r0,7
    put(32'h08, 32'h00221820);  // add  r3,r1,r2
    put(32'h0C, 32'hAC030080);  // sw   r3,0x80(r0)
    put(32'h10, 32'h8C040080);  // lw   r4,0x80(r0)
    put(32'h14, 32'hAC040084);  // sw   r4,0x84(r0)
    put(32'h18, 32'h08000006);  // j    0x18
  endtask

  task automatic load_prog_c(input logic [31:0] beq_word);
    put(32'h00, 32'h20010005);  // addi r1,r0,5
    put(32'h04, 32'h20020007);  // addi r2,r0,7
    put(32'h08, 32'h20000009);  // addi r0,r0,9
    put(32'h0C, 32'h00002820);  // add  r5,r0,r0
    put(32'h10, beq_word);
    put(32'h14, 32'hAC050088);  // sw   r5,0x88(r0)
    put(32'h18, 32'h08000006);  // j    0x18
    put(32'h1C, 32'hAC05008C);  // sw   r5,0x8C(r0)
    put(32'h20, 32'h08000008);  // j    0x20
    put(32'h88, 32'hDEADBEEF);
    put(32'h8C, 32'hDEADBEEF);
  endtask

  initial begin
    // A: zero-wait arithmetic, store/load, latencies
    hold_reset(0, 1'b0);
    load_prog_a();
    run(1);
    reset_state_checks("A");
    Reset = 1'b0;
    run(12);
    chk("A_add_alu", ALU_out, 32'd12);
    chk("A_add_retire", 32'(retire), 32'h1);
    run(28);
    chk("A_rt0_cyc", rt_cyc[0], 4);
    chk("A_rt1_cyc", rt_cyc[1], 8);
    chk("A_rt2_cyc", rt_cyc[2], 12);
    chk("A_sw_cyc", rt_cyc[3], 16);
    chk("A_lw_cyc", rt_cyc[4], 21);
    chk("A_j_lat", rt_cyc[6] - rt_cyc[5], 3);
    chk("A_mem80", mem[32], 32'd12);
    chk("A_mem84", mem[33], 32'd12);
    chk("A_memout", MEM_out, 32'd12);
    chk("A_alu_end", ALU_out, 32'h84);
    chk("A_no_illegal", ill_n, 0);

    // B: three wait states on every access
    hold_reset(3, 1'b0);
    put(32'h00, 32'h2003000C);  // addi r3,r0,12
    put(32'h04, 32'hAC030000);  // sw   r3,0(r0)
    put(32'h08, 32'h8C040000);  // lw   r4,0(r0)
    put(32'h0C, 32'hAC040084);  // sw   r4,0x84(r0)
    put(32'h10, 32'h08000004);  // j    0x10
    release_reset();
    run(45);
    chk("B_addi_cyc", rt_cyc[0], 7);
    chk("B_sw_cyc", rt_cyc[1], 17);
    chk("B_lw_lat", rt_cyc[2] - rt_cyc[1], 11);
    chk("B_wr0_addr", wr_addr[0], 32'h0);
    chk("B_wr0_data", wr_data[0], 32'd12);
    chk("B_mem84", mem[33], 32'd12);
    chk("B_stable", stab_viol, 0);

    // C1: taken beq, ready held high throughout
    hold_reset(0, 1'b1);
    load_prog_c(32'h10210002);  // beq r1,r1,+2
    run(1);
    reset_state_checks("C1");
    Reset = 1'b0;
    run(30);
    chk("C1_beq_fetch", f_addr[4], 32'h10);
    chk("C1_target", f_addr[5], 32'h1C);
    chk("C1_beq_lat", rt_cyc[4] - rt_cyc[3], 3);
    chk("C1_r5_zero", mem[35], 32'h0);
    chk("C1_not_fall", mem[34], 32'hDEADBEEF);

    // C2: untaken beq
    hold_reset(0, 1'b1);
    load_prog_c(32'h10220002);  // beq r1,r2,+2
    release_reset();
    run(30);
    chk("C2_target", f_addr[5], 32'h14);
    chk("C2_r5_zero", mem[34], 32'h0);
    chk("C2_not_taken", mem[35], 32'hDEADBEEF);

    // D: ALU ops, wraparound, illegal opcode, jal
    hold_reset(0, 1'b0);
    put(32'h00, 32'h8C060090);  // lw   r6,0x90(r0)
    put(32'h04, 32'h20070001);  // addi r7,r0,1
    put(32'h08, 32'h00C74020);  // add  r8,r6,r7
    put(32'h0C, 32'h00E64822);  // sub  r9,r7,r6
    put(32'h10, 32'h0107502A);  // slt  r10,r8,r7
    put(32'h14, 32'h00C85824);  // and  r11,r6,r8
    put(32'h18, 32'h00C86025);  // or   r12,r6,r8
    put(32'h1C, 32'hFC0C0000);  // opcode 3Fh
    put(32'h20, 32'hAC080094);  // sw   r8,0x94(r0)
    put(32'h24, 32'hAC090098);  // sw   r9,0x98(r0)
    put(32'h28, 32'hAC0A009C);  // sw   r10,0x9C(r0)
    put(32'h2C, 32'hAC0B00A0);  // sw   r11,0xA0(r0)
    put(32'h30, 32'hAC0C00A4);  // sw   r12,0xA4(r0)
    put(32'h34, 32'h08000010);  // j    0x40
    put(32'h40, 32'h0C000014);  // jal  0x50
    put(32'h44, 32'h08000011);  // j    0x44
    put(32'h50, 32'hAC1F00A8);  // sw   r31,0xA8(r0)
    put(32'h54, 32'h08000015);  // j    0x54
    put(32'h90, 32'h7FFFFFFF);
    put(32'hA8, 32'hDEADBEEF);
    release_reset();
    run(110);
    chk("D_add_wrap", mem[37], 32'h80000000);
    chk("D_sub", mem[38], 32'h80000002);
    chk("D_slt_signed", mem[39], 32'h1);
    chk("D_and", mem[40], 32'h0);
    chk("D_or_kept", mem[41], 32'hFFFFFFFF);
    chk("D_ill_with_retire", ill_alone, 0);
`ifdef MULTI_CYCLE_CORE_JAL_EN
    chk("D_ill_count", ill_n, 1);
    chk("D_jal_r31", mem[42], 32'h44);
`else
    chk("D_ill_count", ill_n, 2);
    chk("D_jal_r31", mem[42], 32'hDEADBEEF);
`endif

    // E: reset during a fetch wait
    hold_reset(2, 1'b0);
    load_prog_a();
    release_reset();
    run(8);
    chk("E_wait_req", 32'(mem_req), 32'h1);
    chk("E_wait_pc", PC_out, 32'h4);
    Reset = 1'b1;
    run(1);
    chk("E_abort_req", 32'(mem_req), 32'h0);
    chk("E_abort_pc", PC_out, 32'h0);
    chk("E_abort_retire", 32'(retire), 32'h0);
    delay = 0;
    run(1);
    Reset = 1'b0;
    run(4);
    chk("E_first_fetch", f_addr[0], 32'h0);
    chk("E_retire_c4", 32'(retire), 32'h1);
    chk("E_pc_c4", PC_out, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_cycle_core.md
MULTI_CYCLE_CORE -- requirements
Module: multi_cycle_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter ADDR_W, default 32: width of mem_addr; PC is 32 bits internally, low ADDR_W bits driven.
REQ-003 SHALL have ports in this order:
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- mem_ready  in  1  access completes this cycle.
- PC_out  out  32  current PC.
- ALU_out  out  32  registered ALU result.
- MEM_out  out  32  registered load data.
- retire  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  one-cycle pulse on an undecoded opcode/funct.

Function
REQ-004 SHALL implement the MIPS subset: R-type add(20h), sub(22h), and(24h), or(25h), slt(2Ah, signed); lw(23h), sw(2Bh), beq(04h), addi(08h), j(02h); instructions are 32-bit big-field MIPS encoding.
REQ-005 SHALL use a single unified memory port for fetch and data.
REQ-006 SHALL use FSM states FETCH, DECODE, EXEC, MEM, WB; reset state is FETCH.
REQ-007 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready, latch IR, set PC=PC+4, go to DECODE; otherwise remain in FETCH.
REQ-008 DECODE: read rs/rt into A/B, sign-extend imm16, go to EXEC; illegal encoding pulses illegal and retire, then returns to FETCH (executes as nop).
REQ-009 EXEC: R-type/addi -> compute, go to WB; lw/sw -> ALU_out=A+simm, go to MEM; beq -> if A==B then PC=PC+(simm<<2), retire, go to FETCH; j -> PC={PC[31:28],IR[25:0],2'b00}, retire, go to FETCH.
REQ-010 MEM: mem_req=1, mem_addr=ALU_out; sw: mem_we=1, mem_wdata=B, retire on mem_ready, then FETCH; lw: mem_we=0, MEM_out=mem_rdata on mem_ready, then WB.
REQ-011 WB: write rd (R-type), rt (addi) or MEM_out (lw) into the register file, pulse retire, go to FETCH.
REQ-012 mem_addr, mem_we, and mem_wdata SHALL remain stable while mem_req=1 and mem_ready=0; mem_req SHALL be 0 in DECODE, EXEC and WB.
REQ-013 mem_ready arriving while mem_req=0 SHALL be ignored.
REQ-014 SHALL contain a 32x32 register file with 2 read ports and 1 write port; r0 reads 0 and ignores writes.
REQ-015 Arithmetic SHALL wrap modulo 2^32; no overflow traps.
REQ-016 Minimum latency with zero wait states: R-type/addi/sw 4 cycles, lw 5, beq/j 3; each memory wait cycle adds 1.
REQ-017 PC SHALL wrap from 32'hFFFF_FFFC to 0.

Reset
REQ-018 While Reset=1 at a rising edge: state=FETCH, PC=RESET_PC, ALU_out=0, MEM_out=0, IR=0, all registers=0, retire=0, illegal=0.
REQ-019 Reset asserted mid-access SHALL abort the access; mem_req SHALL be 0 in the cycle after Reset is sampled high, and the in-flight instruction SHALL NOT retire.

Configuration
REQ-020 Macro MULTI_CYCLE_CORE_JAL_EN: when defined, opcode 03h (jal) is legal; in EXEC it writes the already-incremented PC (PC+4 of jal) to r31, jumps as j, retires (3 cycles).
REQ-021 When the macro is undefined, opcode 03h is illegal per REQ-008.

Verification
REQ-022 Zero-wait memory, program addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> r3=12, three retire pulses at cycles 4, 8, 12 after reset release.
REQ-023 sw r3,0(r0) then lw r4,0(r0) with mem_ready delayed 3 cycles on every access -> mem write of 12 at address 0; r4=12; lw takes 5+6=11 cycles.
REQ-024 beq r1,r1,+2 at PC=0x10 -> next fetch at 0x1C; beq r1,r2 (unequal) -> next fetch at 0x14.
REQ-025 Reset raised during a FETCH wait -> mem_req=0 the next cycle, PC=RESET_PC, no retire; first fetch after release is from RESET_PC.
REQ-026 Opcode 3Fh -> illegal and retire pulse together, registers unchanged; jal at 0x40 with MULTI_CYCLE_CORE_JAL_EN defined -> r31=0x44, else illegal pulses.
REQ-027 addi r0,r0,9 then add r5,r0,r0 -> r5=0; add of 0x7FFFFFFF+1 -> 0x80000000 with no trap.
